// File: rtl/hart_mailbox_pkg.sv
// hart_mailbox_pkg: shared constants and register map for the inter-hart mailbox
package hart_mailbox_pkg;
  localparam int MBOX_DEPTH = 8;
  localparam int MBOX_DESTW = 8;
  typedef enum logic [1:0] {
    MBOX_TX_DEST = 2'd0,
    MBOX_TX_DATA = 2'd1,
    MBOX_RX_DATA = 2'd2,
    MBOX_STATUS  = 2'd3
  } mbox_reg_e;
  function automatic int hart_w(input int n);
    return $clog2(n) > 0 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hart_mailbox_if.sv
// hart_mailbox_if: packed per-core dbus slice of the mailbox region
interface hart_mailbox_if #(parameter int NCORES = 4);
  logic [NCORES-1:0]    re;
  logic [NCORES-1:0]    we;
  logic [4*NCORES-1:0]  addr;
  logic [32*NCORES-1:0] wdata;
  logic [32*NCORES-1:0] rdata;
  logic [NCORES-1:0]    stall;
  logic [NCORES-1:0]    irq;
  modport master(output re, we, addr, wdata, input rdata, stall, irq);
  modport slave(input re, we, addr, wdata, output rdata, stall, irq);
endinterface

// File: rtl/hart_mailbox_fifo.sv
// hart_mailbox_fifo: sync FIFO with same-cycle push/pop and a combinational head
module hart_mailbox_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign dout  = mem[rp];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/hart_mailbox.sv
// hart_mailbox: per-hart RX FIFOs with round-robin push arbitration per destination
module hart_mailbox
  import hart_mailbox_pkg::*;
#(
  parameter int NCORES = 4,
  parameter int DEPTH  = MBOX_DEPTH
) (
  input logic clk_i,
  input logic rst_i,
  hart_mailbox_if.slave bus
);
  localparam int HARTW = hart_w(NCORES);
  localparam int CW = $clog2(DEPTH) + 1;
  mbox_reg_e             sel      [NCORES];
  logic [MBOX_DESTW-1:0] tx_dest  [NCORES];
  logic [HARTW-1:0]      rr_ptr   [NCORES];
  logic [HARTW-1:0]      win      [NCORES];
  logic [HARTW+31:0]     din      [NCORES];
  logic [HARTW+31:0]     head     [NCORES];
  logic [CW-1:0]         count    [NCORES];
  logic [31:0]           rval     [NCORES];
  logic [31:0]           rdata_q  [NCORES];
  logic [NCORES-1:0] push_req, dest_ok, gnt, ov_set, bad_set, ov_clr, bad_clr;
  logic [NCORES-1:0] overflow, bad_dest, any, push, pop, full, empty, irq_q;
  function automatic logic [HARTW-1:0] rr_idx(input logic [HARTW-1:0] p, input int k);
    return HARTW'((int'(p) + k) % NCORES);
  endfunction
  for (genvar s = 0; s < NCORES; s++) begin : g_src
    logic [HARTW-1:0] dd;
    logic             unused_addr;
    assign unused_addr = ^bus.addr[4*s +: 2];
    assign sel[s]      = mbox_reg_e'(bus.addr[4*s+2 +: 2]);
    assign dd          = tx_dest[s][HARTW-1:0];
    assign dest_ok[s]  = tx_dest[s] < MBOX_DESTW'(NCORES);
    assign push_req[s] = !rst_i && bus.we[s] && sel[s] == MBOX_TX_DATA;
    assign gnt[s]      = push_req[s] && dest_ok[s] && any[dd] && win[dd] == HARTW'(s);
    assign bus.stall[s] = push_req[s] && dest_ok[s] && !gnt[s];
    // A granted word that finds the FIFO full is dropped rather than stalled
    assign ov_set[s]   = gnt[s] && !push[dd];
    assign bad_set[s]  = push_req[s] && !dest_ok[s];
    assign ov_clr[s]   = !rst_i && bus.we[s] && sel[s] == MBOX_STATUS && bus.wdata[32*s+2];
    assign bad_clr[s]  = !rst_i && bus.we[s] && sel[s] == MBOX_STATUS && bus.wdata[32*s+3];
    assign pop[s]      = !rst_i && bus.re[s] && sel[s] == MBOX_RX_DATA && !empty[s];
    assign rval[s] = sel[s] == MBOX_TX_DEST ? 32'(tx_dest[s]) :
                     sel[s] == MBOX_RX_DATA ? (empty[s] ? 32'd0 : head[s][31:0]) :
                     sel[s] == MBOX_STATUS  ? {8'd0, empty[s] ? 8'd0 : 8'(head[s][HARTW+31:32]),
                                               8'(count[s]), 4'd0, bad_dest[s], overflow[s],
                                               dest_ok[s] && full[dd], !empty[s]} : 32'd0;
    assign bus.rdata[32*s +: 32] = rdata_q[s];
  end
  for (genvar d = 0; d < NCORES; d++) begin : g_arb
    logic [NCORES-1:0] req;
    logic [HARTW-1:0]  w;
    logic              hit;
    for (genvar s = 0; s < NCORES; s++) begin : g_req
      assign req[s] = push_req[s] && dest_ok[s] && tx_dest[s] == MBOX_DESTW'(d);
    end
    always_comb begin
      hit = 1'b0;
      w   = '0;
      for (int k = 0; k < NCORES; k++)
        if (!hit && req[rr_idx(rr_ptr[d], k)]) begin
          hit = 1'b1;
          w   = rr_idx(rr_ptr[d], k);
        end
    end
    assign any[d]  = hit;
    assign win[d]  = w;
    assign push[d] = hit && (!full[d] || pop[d]);
    assign din[d]  = {w, bus.wdata[32*w +: 32]};
    hart_mailbox_fifo #(.DEPTH(DEPTH), .W(HARTW+32)) u_fifo (
      .clk(clk_i), .rst(rst_i), .push(push[d]), .pop(pop[d]), .din(din[d]),
      .dout(head[d]), .count(count[d]), .full(full[d]), .empty(empty[d])
    );
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      overflow <= '0;
      bad_dest <= '0;
      irq_q    <= '0;
      for (int i = 0; i < NCORES; i++) begin
        tx_dest[i] <= '0;
        rr_ptr[i]  <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      overflow <= (overflow & ~ov_clr) | ov_set;
      bad_dest <= (bad_dest & ~bad_clr) | bad_set;
      for (int i = 0; i < NCORES; i++) begin
        rdata_q[i] <= bus.re[i] ? rval[i] : 32'd0;
        if (bus.we[i] && sel[i] == MBOX_TX_DEST) tx_dest[i] <= bus.wdata[32*i +: MBOX_DESTW];
        if (any[i]) rr_ptr[i] <= win[i] == HARTW'(NCORES-1) ? '0 : win[i] + 1'b1;
        irq_q[i] <= push[i] || count[i] > CW'(pop[i]);
      end
    end
  assign bus.irq = irq_q;
endmodule

// File: tb/tb_hart_mailbox.sv
// tb_hart_mailbox: table-driven directed bench with hand sequences for full FIFO and reset
module tb_hart_mailbox;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hart_mailbox_if #(.NCORES(4)) bus();
  hart_mailbox #(.NCORES(4), .DEPTH(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  typedef struct {
    logic [3:0]   re;
    logic [3:0]   we;
    logic [7:0]   sel;
    logic [127:0] wd;
    logic [3:0]   stall;
    int           hart;
    logic [31:0]  rd;
    logic [3:0]   irq_m;
    logic [3:0]   irq;
  } vec_t;
  vec_t tbl [21];
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] stall_s;
  function automatic vec_t mkv(input logic [3:0] re, input logic [3:0] we, input logic [7:0] sel,
                               input logic [127:0] wd, input logic [3:0] st, input int h,
                               input logic [31:0] rd, input logic [3:0] im, input logic [3:0] iv);
    vec_t v;
    v.re = re; v.we = we; v.sel = sel; v.wd = wd; v.stall = st;
    v.hart = h; v.rd = rd; v.irq_m = im; v.irq = iv;
    return v;
  endfunction
  function automatic logic [127:0] w1(input int h, input logic [31:0] x);
    return 128'(x) << (32*h);
  endfunction
  function automatic logic [31:0] rd(input int h);
    return bus.rdata[32*h +: 32];
  endfunction
  task automatic step(input logic [3:0] re, input logic [3:0] we, input logic [7:0] sel,
                      input logic [127:0] wd);
    @(negedge clk);
    bus.re = re;
    bus.we = we;
    bus.wdata = wd;
    for (int i = 0; i < 4; i++) bus.addr[4*i +: 4] = {sel[2*i +: 2], 2'b00};
    #1 stall_s = bus.stall;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %08h expected %08h", nm, id, act, exp);
    end
  endtask
  initial begin
    bus.re = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    // sel packs the register index per hart: bits [2h+1:2h] for hart h
    tbl[0]  = mkv(4'b0000, 4'b1011, 8'h00, {32'd2, 32'd2, 32'd2, 32'd2}, 4'b0000, -1, 0, 4'b0, 4'b0);
    tbl[1]  = mkv(4'b0000, 4'b1011, 8'h45, {32'hA3, 32'h0, 32'hA1, 32'hA0}, 4'b1010, -1, 0, 4'b0, 4'b0);
    tbl[2]  = mkv(4'b0000, 4'b1010, 8'h45, {32'hA3, 32'h0, 32'hA1, 32'hA0}, 4'b1000, -1, 0, 4'b0, 4'b0);
    tbl[3]  = mkv(4'b0000, 4'b1000, 8'h45, {32'hA3, 32'h0, 32'hA1, 32'hA0}, 4'b0000, -1, 0, 4'b0, 4'b0);
    tbl[4]  = mkv(4'b0100, 4'b0000, 8'h30, '0, 4'b0000, 2, 32'h00000301, 4'b0100, 4'b0100);
    tbl[5]  = mkv(4'b0100, 4'b0000, 8'h20, '0, 4'b0000, 2, 32'hA0, 4'b0, 4'b0);
    tbl[6]  = mkv(4'b0100, 4'b0000, 8'h20, '0, 4'b0000, 2, 32'hA1, 4'b0, 4'b0);
    tbl[7]  = mkv(4'b0100, 4'b0000, 8'h20, '0, 4'b0000, 2, 32'hA3, 4'b0, 4'b0);
    tbl[8]  = mkv(4'b0100, 4'b0000, 8'h20, '0, 4'b0000, 2, 32'h0, 4'b0, 4'b0);
    tbl[9]  = mkv(4'b0100, 4'b0000, 8'h30, '0, 4'b0000, 2, 32'h0, 4'b1111, 4'b0000);
    tbl[10] = mkv(4'b0000, 4'b0010, 8'h00, w1(1, 32'd2), 4'b0000, -1, 0, 4'b0, 4'b0);
    tbl[11] = mkv(4'b0000, 4'b0010, 8'h04, w1(1, 32'hDEADBEEF), 4'b0000, -1, 0, 4'b0, 4'b0);
    tbl[12] = mkv(4'b0100, 4'b0000, 8'h30, '0, 4'b0000, 2, 32'h00010101, 4'b0100, 4'b0100);
    tbl[13] = mkv(4'b0100, 4'b0000, 8'h20, '0, 4'b0000, 2, 32'hDEADBEEF, 4'b0, 4'b0);
    tbl[14] = mkv(4'b0100, 4'b0000, 8'h30, '0, 4'b0000, 2, 32'h0, 4'b1111, 4'b0000);
    tbl[15] = mkv(4'b0000, 4'b1000, 8'h00, w1(3, 32'd5), 4'b0000, -1, 0, 4'b0, 4'b0);
    tbl[16] = mkv(4'b1000, 4'b0000, 8'h00, '0, 4'b0000, 3, 32'd5, 4'b0, 4'b0);
    tbl[17] = mkv(4'b0000, 4'b1000, 8'h40, w1(3, 32'h1234), 4'b0000, -1, 0, 4'b0, 4'b0);
    tbl[18] = mkv(4'b1000, 4'b0000, 8'hC0, '0, 4'b0000, 3, 32'h8, 4'b0, 4'b0);
    tbl[19] = mkv(4'b0000, 4'b1000, 8'hC0, w1(3, 32'h8), 4'b0000, -1, 0, 4'b0, 4'b0);
    tbl[20] = mkv(4'b1000, 4'b0000, 8'hC0, '0, 4'b0000, 3, 32'h0, 4'b0, 4'b0);
    step('0, '0, '0, '0);
    step('0, '0, '0, '0);
    for (int h = 0; h < 4; h++) chk("rst_rdata", h, rd(h), 32'h0);
    chk("rst_irq", 0, 32'(bus.irq), 32'h0);
    chk("rst_stall", 0, 32'(stall_s), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].re, tbl[i].we, tbl[i].sel, tbl[i].wd);
      chk("stall", i, 32'(stall_s), 32'(tbl[i].stall));
      if (tbl[i].hart >= 0) chk("rdata", i, rd(tbl[i].hart), tbl[i].rd);
      if (tbl[i].irq_m != 4'b0) chk("irq", i, 32'(bus.irq & tbl[i].irq_m), 32'(tbl[i].irq));
    end
    // hart1 fills FIFO[0], overflows it, then pushes alongside a pop by hart0
    step('0, 4'b0010, 8'h00, w1(1, 32'd0));
    for (int i = 0; i < 8; i++) step('0, 4'b0010, 8'h04, w1(1, 32'h100 + 32'(i)));
    step(4'b0001, '0, 8'h03, '0);
    chk("full_st0", 0, rd(0), 32'h00010801);
    step(4'b0010, '0, 8'h0C, '0);
    chk("full_st1", 0, rd(1), 32'h2);
    step('0, 4'b0010, 8'h04, w1(1, 32'h109));
    chk("ovf_stall", 0, 32'(stall_s), 32'h0);
    step(4'b0010, '0, 8'h0C, '0);
    chk("ovf_st1", 0, rd(1), 32'h6);
    step(4'b0001, '0, 8'h03, '0);
    chk("ovf_st0", 0, rd(0), 32'h00010801);
    step(4'b0001, 4'b0010, 8'h06, w1(1, 32'h10A));
    chk("popsh_rd", 0, rd(0), 32'h100);
    step(4'b0001, '0, 8'h03, '0);
    chk("popsh_st0", 0, rd(0), 32'h00010801);
    for (int i = 1; i <= 8; i++) begin
      step(4'b0001, '0, 8'h02, '0);
      chk("drain", i, rd(0), i < 8 ? 32'h100 + 32'(i) : 32'h10A);
    end
    step('0, 4'b0010, 8'h0C, w1(1, 32'h4));
    step(4'b0010, '0, 8'h0C, '0);
    chk("ovf_clr", 0, rd(1), 32'h0);
    // reset with words queued and a push pending
    step('0, 4'b0010, 8'h00, w1(1, 32'd2));
    for (int i = 0; i < 3; i++) step('0, 4'b0010, 8'h04, w1(1, 32'h200 + 32'(i)));
    step(4'b0100, '0, 8'h30, '0);
    chk("pre_st2", 0, rd(2), 32'h00010301);
    chk("pre_irq", 0, 32'(bus.irq), 32'h4);
    rst = 1'b1;
    step(4'b0100, 4'b0010, 8'h34, w1(1, 32'hBAD));
    chk("rst_stall2", 0, 32'(stall_s), 32'h0);
    chk("rst_rd2", 0, rd(2), 32'h0);
    chk("rst_irq2", 0, 32'(bus.irq), 32'h0);
    rst = 1'b0;
    step(4'b0100, '0, 8'h30, '0);
    chk("post_st2", 0, rd(2), 32'h0);
    step(4'b0010, '0, 8'h00, '0);
    chk("post_dest1", 0, rd(1), 32'h0);
    chk("post_irq", 0, 32'(bus.irq), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
